hs4p_rx_sync: RTL and testbench
===============================

HS4P_RX_SYNC -- requirements
Module: hs4p_rx_sync

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, giving the bundled-data and output word width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-003 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port req_in, input, 1 bit: 4-phase request from the asynchronous sender, asynchronous to clk.
REQ-005 SHALL have port data_in, input, DATA_BITS: bundled data, stable from before the req_in rise until ack_out is seen high.
REQ-006 SHALL have port ack_out, output, 1 bit: 4-phase acknowledge to the sender, registered.
REQ-007 SHALL have port valid_out, output, 1 bit: data_out holds an unconsumed word.
REQ-008 SHALL have port data_out, output, DATA_BITS: captured word, registered.
REQ-009 SHALL have port ready_in, input, 1 bit: the synchronous consumer accepts the word when valid_out and ready_in are both 1 at a rising edge.
REQ-010 SHALL have port xfer_cnt, output, 8 bits: count of completed captures, registered.

Function
REQ-011 SHALL pass req_in through a 2-flop synchronizer; the second flop output is req_s, and only req_s is used by the logic.
REQ-012 SHALL implement a two-state FSM: IDLE (ack_out=0) and ACKED (ack_out=1).
REQ-013 In IDLE with req_s=1 and (valid_out=0 or ready_in=1), the block SHALL at that edge load data_in into data_out, set valid_out=1, set ack_out=1, increment xfer_cnt and enter ACKED.
REQ-014 In IDLE with req_s=1, valid_out=1 and ready_in=0, the block SHALL stall: no capture, and ack_out stays 0.
REQ-015 In ACKED, the block SHALL hold ack_out=1 until req_s=0, then clear ack_out and enter IDLE at that edge.
REQ-016 A consume (valid_out & ready_in) without a simultaneous capture SHALL clear valid_out at that edge; data_out is held.
REQ-017 Consume and capture at the same edge SHALL leave valid_out=1 with the new word, giving a back-to-back transfer with no gap.
REQ-018 Latency: with req_in rising before edge 0, req_s is high after edge 1, and ack_out and valid_out are high after edge 2.
REQ-019 Return-to-zero latency: with req_in falling before edge k, ack_out is low after edge k+2.
REQ-020 xfer_cnt SHALL wrap from 255 to 0 with no flag.
REQ-021 The block SHALL never capture twice for one req_in high phase.
REQ-022 data_in SHALL be sampled only at the capture edge.

Reset
REQ-023 While rstn=0, all of the following SHALL be 0, asynchronously: both synchronizer flops, FSM state (IDLE), ack_out, valid_out, data_out and xfer_cnt.
REQ-024 Reset release SHALL be synchronous to clk (flops leave reset on a clean edge).
REQ-025 If req_in is still high after reset release, it SHALL be treated as a new request and captured after the synchronizer latency.
REQ-026 A reset asserted mid-handshake SHALL drop ack_out immediately, and the lost word SHALL not be reported.

Configuration
REQ-027 With macro HS4P_RX_SYNC3_EN defined, the synchronizer SHALL be 3 flops, and each latency in REQ-018 and REQ-019 grows by one cycle.
REQ-028 Without HS4P_RX_SYNC3_EN, the synchronizer SHALL be 2 flops as in REQ-011.

Verification
REQ-029 Single transfer, DATA_BITS=8, ready_in=1: data_in=0xA5, req_in rises before edge 0 -> ack_out=1, valid_out=1, data_out=0xA5 after edge 2, xfer_cnt=1; req_in falls before edge 5 -> ack_out=0 after edge 7.
REQ-030 Backpressure, ready_in=0: first word 0x11 captured; second request with 0x22 -> ack_out stays 0 and data_out stays 0x11; ready_in=1 for one edge -> 0x22 captured at that edge and valid_out remains 1.
REQ-031 Wrap: 256 complete handshakes -> xfer_cnt=0, and every data_out matches its data_in (incrementing pattern 0x00..0xFF).
REQ-032 Reset mid-handshake: rstn=0 while ack_out=1 -> ack_out=0, valid_out=0, xfer_cnt=0 immediately; req_in still high at release -> recapture after 3 edges.
REQ-033 Long request, req_in held high 20 cycles -> exactly one capture, xfer_cnt increments by 1.
REQ-034 With HS4P_RX_SYNC3_EN, repeat REQ-029 -> ack_out high after edge 3 and low after edge 8.

Source files
------------

// File: rtl/hs4p_rx_sync.sv
// hs4p_rx_sync: receives words over a 4-phase bundled-data handshake from an
// asynchronous sender and hands them to a synchronous valid/ready consumer.
//
// Ports:
//   clk        - single clock, rising edge active
//   rstn       - asynchronous active-low reset
//   req_in     - 4-phase request from the sender (asynchronous to clk)
//   data_in    - bundled data, stable while req_in is high until ack_out is seen
//   ack_out    - 4-phase acknowledge back to the sender (registered)
//   valid_out  - data_out holds a word the consumer has not taken yet
//   data_out   - captured word (registered)
//   ready_in   - consumer takes the word when valid_out & ready_in at an edge
//   xfer_cnt   - count of completed captures, wraps 255 -> 0
//
// Build option: define HS4P_RX_SYNC3_EN for a 3-flop req_in synchronizer
// (every handshake latency grows by one cycle). The default is 2 flops.
module hs4p_rx_sync #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ack_out,
  output logic                 valid_out,
  output logic [DATA_BITS-1:0] data_out,
  input  logic                 ready_in,
  output logic [7:0]           xfer_cnt
);

`ifdef HS4P_RX_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  typedef enum logic {IDLE = 1'b0, ACKED = 1'b1} state_t;

  logic [SYNC_N-1:0] sync_pipe;
  logic              req_s;
  state_t            state, state_nxt;
  logic              capture;
  logic              consume;

  // req_in is asynchronous; nothing but the last synchronizer stage is used.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_N-2:0], req_in};
  end

  assign req_s   = sync_pipe[SYNC_N-1];
  assign consume = valid_out & ready_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // A capture only happens on the IDLE->ACKED step, and ACKED is only left
  // once req_s drops, so one request high phase yields exactly one word.
  // The capture may overwrite data_out only if it is empty or being consumed
  // at the same edge; otherwise the sender is stalled by withholding ack.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && (!valid_out || ready_in)) begin
          capture   = 1'b1;
          state_nxt = ACKED;
        end
      end
      ACKED: begin
        if (!req_s) state_nxt = IDLE;
      end
    endcase
  end

  // ack_out comes straight from the state flop, so it is glitch-free and
  // drops the moment reset asserts.
  assign ack_out = (state == ACKED);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      xfer_cnt  <= '0;
    end else if (capture) begin
      // Covers a simultaneous consume too: valid stays up with the new word.
      valid_out <= 1'b1;
      data_out  <= data_in;
      xfer_cnt  <= xfer_cnt + 8'd1;
    end else if (consume) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hs4p_rx_sync.sv
// Directed bench for hs4p_rx_sync: single transfer latency, backpressure,
// counter wrap with data pattern, reset mid-handshake, long request.
// Latencies scale with the synchronizer depth selected by HS4P_RX_SYNC3_EN.
module tb_hs4p_rx_sync;

`ifdef HS4P_RX_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  logic       clk;
  logic       rstn;
  logic       req_in;
  logic [7:0] data_in;
  logic       ack_out;
  logic       valid_out;
  logic [7:0] data_out;
  logic       ready_in;
  logic [7:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  hs4p_rx_sync #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_out   (ack_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One active edge, then settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (ack_out !== lvl && n < 20) begin
      tick();
      n++;
    end
    chk(tag, ack_out, lvl);
  endtask

  // Full 4-phase handshake; checks the captured word when ack rises.
  task automatic do_xfer(input logic [7:0] d);
    data_in = d;
    req_in  = 1'b1;
    wait_ack(1'b1, "xfer_ack_hi");
    chk("xfer_data", data_out, d);
    req_in = 1'b0;
    wait_ack(1'b0, "xfer_ack_lo");
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_ack", ack_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_cnt", xfer_cnt, 0);
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    int e;
    logic [7:0] c0;
    rstn = 1'b0; req_in = 1'b0; data_in = 8'h00; ready_in = 1'b1;
    #2;
    do_reset();

    // Single transfer: req rises before edge 0.
    data_in = 8'hA5;
    req_in  = 1'b1;
    for (int i = 0; i < SYNC_N; i++) begin
      tick();
      chk("lat_ack_early", ack_out, 0);
    end
    tick(); // edge SYNC_N
    chk("lat_ack_hi", ack_out, 1);
    chk("lat_valid_hi", valid_out, 1);
    chk("lat_data", data_out, 8'hA5);
    chk("lat_cnt", xfer_cnt, 1);
    data_in = 8'hFF; // must not be sampled after the capture edge
    e = SYNC_N;
    tick(); e++;
    chk("consume_valid", valid_out, 0);
    chk("hold_data", data_out, 8'hA5);
    while (e < 4) begin tick(); e++; end
    req_in = 1'b0; // falls before edge 5
    for (int i = 0; i < SYNC_N; i++) begin
      tick();
      chk("rtz_ack_still_hi", ack_out, 1);
    end
    tick(); // edge 5+SYNC_N
    chk("rtz_ack_lo", ack_out, 0);
    chk("rtz_cnt", xfer_cnt, 1);
    chk("rtz_data", data_out, 8'hA5);

    // Backpressure.
    do_reset();
    ready_in = 1'b0;
    do_xfer(8'h11);
    chk("bp_valid1", valid_out, 1);
    data_in = 8'h22;
    req_in  = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_stall_ack", ack_out, 0);
    chk("bp_stall_data", data_out, 8'h11);
    chk("bp_stall_valid", valid_out, 1);
    chk("bp_stall_cnt", xfer_cnt, 1);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk("bp_cap_data", data_out, 8'h22);
    chk("bp_cap_valid", valid_out, 1);
    chk("bp_cap_ack", ack_out, 1);
    chk("bp_cap_cnt", xfer_cnt, 2);
    req_in = 1'b0;
    wait_ack(1'b0, "bp_ack_lo");
    chk("bp_valid_held", valid_out, 1);
    ready_in = 1'b1;
    tick();
    chk("bp_drain_valid", valid_out, 0);

    // Wrap over 256 handshakes with incrementing data.
    do_reset();
    for (int i = 0; i < 255; i++) do_xfer(i[7:0]);
    chk("wrap_cnt_255", xfer_cnt, 8'd255);
    do_xfer(8'hFF);
    chk("wrap_cnt_0", xfer_cnt, 8'd0);

    // Reset mid-handshake, request still high at release.
    do_reset();
    do_xfer(8'h3C);
    data_in = 8'h5A;
    req_in  = 1'b1;
    wait_ack(1'b1, "mid_ack_hi");
    chk("mid_cnt_pre", xfer_cnt, 2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ack", ack_out, 0);
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_cnt", xfer_cnt, 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < SYNC_N; i++) begin
      tick();
      chk("mid_rel_ack_lo", ack_out, 0);
    end
    tick();
    chk("mid_recap_ack", ack_out, 1);
    chk("mid_recap_data", data_out, 8'h5A);
    chk("mid_recap_cnt", xfer_cnt, 1);
    req_in = 1'b0;
    wait_ack(1'b0, "mid_ack_lo");

    // Long request: one capture only.
    c0 = xfer_cnt;
    data_in = 8'h77;
    req_in  = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("long_cnt", xfer_cnt, c0 + 8'd1);
    chk("long_ack", ack_out, 1);
    req_in = 1'b0;
    wait_ack(1'b0, "long_ack_lo");
    for (int i = 0; i < 4; i++) tick();
    chk("long_cnt_after", xfer_cnt, c0 + 8'd1);
    chk("long_data", data_out, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
